// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Brief    : Single-outstanding instruction fetch stage feeding decode; PC
//            redirects flush in-flight work. Optional FETCH_STATS_EN adds
//            fetched/flushed counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
`ifdef FETCH_STATS_EN
    output logic [31:0]     stat_fetched,
    output logic [31:0]     stat_flushed,
`endif
    output logic [6:0]      opcode
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t          r_state, w_state_next;
    logic [XLEN-1:0] r_pc, w_pc_next;
    logic [XLEN-1:0] r_addr, w_addr_next;
    logic [XLEN-1:0] r_instr, w_instr_next;
    logic [XLEN-1:0] r_instr_pc, w_instr_pc_next;
    logic            r_valid, w_valid_next;
    logic [XLEN-1:0] w_target;

    assign w_target = redirect_pc & ~XLEN'(3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_addr_next     = r_addr;
        w_instr_next    = r_instr;
        w_instr_pc_next = r_instr_pc;
        w_valid_next    = r_valid;
        case (r_state)
            S_IDLE: begin
                w_state_next = S_REQ;
                if (redirect_valid) w_pc_next = w_target;
            end
            S_REQ: begin
                if (redirect_valid) begin
                    // Un-acked request must still complete at its old address.
                    w_pc_next    = w_target;
                    w_state_next = imem_ack ? S_REQ : S_DRAIN;
                end else if (imem_ack) begin
                    w_instr_next    = imem_rdata;
                    w_instr_pc_next = r_pc;
                    w_pc_next       = r_pc + XLEN'(4);
                    w_valid_next    = 1'b1;
                    w_state_next    = S_VALID;
                end
            end
            S_VALID: begin
                if (redirect_valid || instr_ready) begin
                    if (redirect_valid) w_pc_next = w_target;
                    w_valid_next = 1'b0;
                    w_instr_next = NOP_INSTR;
                    w_state_next = S_REQ;
                end
            end
            S_DRAIN: begin
                if (redirect_valid) w_pc_next = w_target;
                if (imem_ack) w_state_next = S_REQ;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (w_state_next == S_REQ) w_addr_next = w_pc_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_addr     <= RESET_PC;
            r_instr    <= NOP_INSTR;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_addr     <= w_addr_next;
            r_instr    <= w_instr_next;
            r_instr_pc <= w_instr_pc_next;
            r_valid    <= w_valid_next;
        end
    end

    assign imem_req    = (r_state == S_REQ) || (r_state == S_DRAIN);
    assign imem_addr   = r_addr;
    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign opcode      = r_instr[6:0];

`ifdef FETCH_STATS_EN
    logic [31:0] r_stat_fetched, r_stat_flushed;
    logic        w_fetch_evt, w_flush_evt;

    assign w_fetch_evt = r_valid & instr_ready & ~redirect_valid;
    // A redirect in DRAIN discards nothing new; that request was counted already.
    assign w_flush_evt = redirect_valid & ((r_state == S_VALID) || (r_state == S_REQ));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_fetched <= '0;
            r_stat_flushed <= '0;
        end else begin
            if (w_fetch_evt) r_stat_fetched <= r_stat_fetched + 32'd1;
            if (w_flush_evt) r_stat_flushed <= r_stat_flushed + 32'd1;
        end
    end

    assign stat_fetched = r_stat_fetched;
    assign stat_flushed = r_stat_flushed;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Scoreboard bench for fetch_unit: transaction-level model predicts
//            delivered instructions; a monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    localparam logic [31:0] c_NOP    = 32'h0000_0013;
    localparam logic [31:0] c_RST_PC = 32'h0000_0000;
    localparam logic [31:0] c_WRAP_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, redirect_valid = 1'b0, imem_ack = 1'b0, instr_ready = 1'b0;
    logic [31:0] redirect_pc = '0, imem_rdata = '0;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, instr_pc;
    logic [6:0]  opcode;

    logic        b_rst = 1'b1, b_ack = 1'b0, b_ready = 1'b0;
    logic        b_req, b_valid;
    logic [31:0] b_addr, b_instr, b_instr_pc;
    logic [6:0]  b_opcode;

    fetch_unit u_dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .opcode(opcode)
    );

    fetch_unit #(.RESET_PC(c_WRAP_PC)) u_dut_wrap (
        .clk(clk), .rst(b_rst), .redirect_valid(1'b0), .redirect_pc(32'h0),
        .imem_req(b_req), .imem_addr(b_addr), .imem_ack(b_ack), .imem_rdata(c_NOP),
        .instr_valid(b_valid), .instr_ready(b_ready), .instr(b_instr),
        .instr_pc(b_instr_pc), .opcode(b_opcode)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } item_t;
    item_t sbq[$];

    // Transaction-level reference: what is outstanding, what is held, where next.
    bit          m_started = 0, m_busy = 0, m_stale = 0, m_hold = 0;
    logic [31:0] m_pc = c_RST_PC, m_addr = c_RST_PC, m_hinstr = c_NOP, m_hpc = '0;

    task automatic model_step(input logic rs, rd, input logic [31:0] rp, input logic ak, rdy);
        logic [31:0] tgt;
        tgt = rp & 32'hFFFF_FFFC;
        if (rs) begin
            m_started = 0; m_busy = 0; m_stale = 0; m_hold = 0;
            m_pc = c_RST_PC; m_addr = c_RST_PC; m_hpc = '0;
        end else if (!m_started) begin
            m_started = 1;
            if (rd) m_pc = tgt;
            m_busy = 1; m_addr = m_pc;
        end else if (m_hold) begin
            if (rd || rdy) begin
                m_hold = 0;
                if (rd) m_pc = tgt;
                m_busy = 1; m_addr = m_pc;
            end
        end else if (m_busy) begin
            if (rd) m_pc = tgt;
            if (ak) begin
                if (rd || m_stale) begin
                    m_stale = 0; m_addr = m_pc;
                end else begin
                    m_hold = 1; m_busy = 0;
                    m_hinstr = mem(m_addr); m_hpc = m_addr;
                    sbq.push_back('{pc: m_addr, ins: m_hinstr});
                    m_pc = m_addr + 32'd4;
                end
            end else if (rd) begin
                m_stale = 1;
            end
        end
    endtask

    // Check current outputs, apply one cycle of stimulus, advance the model.
    task automatic cyc(input logic rs, rd, input logic [31:0] rp, input logic ak, rdy);
        logic [31:0] exp_ins;
        exp_ins = m_hold ? m_hinstr : c_NOP;
        chk("imem_req", {31'b0, imem_req}, {31'b0, m_busy});
        if (m_busy || !m_started) chk("imem_addr", imem_addr, m_addr);
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_hold});
        chk("instr", instr, exp_ins);
        chk("opcode", {25'b0, opcode}, {25'b0, exp_ins[6:0]});
        if (m_hold || !m_started) chk("instr_pc", instr_pc, m_hpc);
        rst = rs; redirect_valid = rd; redirect_pc = rp;
        imem_ack = ak; instr_ready = rdy;
        imem_rdata = ak ? mem(m_addr) : $urandom;
        model_step(rs, rd, rp, ak, rdy);
        @(posedge clk); #1;
    endtask

    bit seen = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (instr_valid && !seen) begin
                seen = 1;
                if (sbq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL deliver: actual pc=0x%08h required=none (queue empty)", instr_pc);
                end else begin
                    item_t it;
                    it = sbq.pop_front();
                    chk("deliver_pc", instr_pc, it.pc);
                    chk("deliver_instr", instr, it.ins);
                    chk("deliver_opcode", {25'b0, opcode}, {25'b0, it.ins[6:0]});
                end
            end else if (!instr_valid) begin
                seen = 0;
            end
        end
    end

    initial begin
        logic [31:0] wrap_addrs[$];
        bit          wrap_pc_ok;
        @(posedge clk); @(posedge clk); #1;
        // Reset, then streaming with ack and ready held high.
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 1);
        // Decode stalls for 5 cycles on a held instruction.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        // Redirect to 0x100 during a slow request at address 0.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 32'h100, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        // Redirect to 0x203 coinciding with instr_ready in VALID.
        cyc(0, 1, 32'h203, 0, 1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        // Reset while draining; a late ack must be ignored.
        cyc(0, 1, 32'h40, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
                (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom),
                $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
        end
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("scoreboard_empty", sbq.size(), 0);

        // PC wrap instance: addresses 0xFFFF_FFFC then 0x0000_0000.
        b_rst = 1'b0; b_ack = 1'b1; b_ready = 1'b1;
        wrap_pc_ok = 0;
        for (int i = 0; i < 12 && wrap_addrs.size() < 2; i++) begin
            @(posedge clk); #1;
            if (b_req) wrap_addrs.push_back(b_addr);
            if (b_valid && !wrap_pc_ok) begin
                wrap_pc_ok = 1;
                chk("wrap_instr_pc", b_instr_pc, c_WRAP_PC);
            end
        end
        if (wrap_addrs.size() < 2) begin
            checks++; failures++;
            $display("FAIL wrap_timeout: actual requests=%0d required=2", wrap_addrs.size());
        end else begin
            chk("wrap_addr0", wrap_addrs[0], c_WRAP_PC);
            chk("wrap_addr1", wrap_addrs[1], 32'h0000_0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the main decoder (`control`). It holds the PC and issues one word request at a time to instruction memory over a req/ack handshake. It presents the fetched instruction, its PC and its 7-bit opcode to decode with a valid/ready handshake. It also accepts PC redirects from branch/jal/jalr resolution and flushes in-flight work when one arrives.

Parameters:
XLEN, 32, width of PC and instruction word
RESET_PC, 32'h0000_0000, PC fetched first after reset
NOP_INSTR, 32'h0000_0013, value driven on instr while nothing valid (addi x0,x0,0)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
redirect_valid  in  1  redirect request from branch/jump resolution, one-cycle pulse or level
redirect_pc  in  XLEN  redirect target; bits [1:0] ignored (treated as 0)
imem_req  out  1  instruction memory request
imem_addr  out  XLEN  word address of the request; stable while imem_req=1 and imem_ack=0
imem_ack  in  1  memory response strobe; rdata valid in the same cycle
imem_rdata  in  XLEN  instruction word returned
instr_valid  out  1  instr/instr_pc/opcode hold a live instruction
instr_ready  in  1  decode accepts the instruction this cycle
instr  out  XLEN  fetched instruction; NOP_INSTR when instr_valid=0
instr_pc  out  XLEN  PC of instr
opcode  out  7  instr[6:0], feeds control directly

Behaviour:
- Single clock, synchronous active-high reset. At most one memory request is outstanding.
- Reset values:
  - state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC
  - instr_valid=0, instr=NOP_INSTR, instr_pc=0, opcode=7'b0010011
- States: IDLE, REQ, VALID, DRAIN.
- IDLE: the cycle after rst deasserts, go to REQ.
- REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: instr<=imem_rdata, instr_pc<=pc, pc<=pc+4, instr_valid<=1, go to VALID.
  - No ack: stay in REQ.
  - ack may arrive in the first REQ cycle, so minimum latency is request cycle to instr_valid = 1 cycle.
- VALID:
  - imem_req=0; instr/instr_pc/opcode held stable while instr_valid=1 and instr_ready=0.
  - On instr_ready: instr_valid<=0, instr<=NOP_INSTR, go to REQ.
  - Peak throughput is 1 instruction per 2 cycles.
- DRAIN: imem_req=1 with the old imem_addr until imem_ack. On ack, discard rdata and go to REQ; instr_valid stays 0.
- Redirect has priority over all other events except rst. pc<=redirect_pc & ~3.
  - IDLE or VALID: instr_valid<=0, instr<=NOP_INSTR, go to REQ. This applies even if instr_ready=1 the same cycle; that instruction counts as dropped.
  - REQ with imem_ack the same cycle: rdata discarded, go to REQ (new pc).
  - REQ without ack: go to DRAIN. The address stays stable because the old request must complete.
  - DRAIN: update pc to the newest target; if ack arrives the same cycle, go to REQ.
- PC arithmetic: modulo 2^XLEN; 0xFFFF_FFFC+4 wraps to 0.
- rst asserted mid-request: return to reset values immediately. Any later imem_ack while not in REQ/DRAIN is ignored.
- opcode is always combinationally equal to instr[6:0].

Optional Feature:
FETCH_STATS_EN
- Defined:
  - Adds outputs stat_fetched (32) and stat_flushed (32), both cleared by rst.
  - stat_fetched increments on each VALID→consumed handshake (instr_valid & instr_ready & !redirect_valid).
  - stat_flushed increments on each redirect that discards a valid instruction or an in-flight request.
  - Both counters wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset then ack held high, instr_ready=1, rdata 0x00000033/0x00002023/0x00000013 → imem_addr 0,4,8; opcode 0110011, 0100011, 0010011 in order; instr_valid high every other cycle.
- Hold instr_ready=0 for 5 cycles after first fetch → instr, instr_pc=0 and opcode stable; imem_req=0; no pc advance.
- Delay ack 3 cycles with redirect_pc=0x100 in the first wait cycle → imem_addr stays 0 until ack; that data is dropped; next request is addr 0x100; instr_valid never asserted for addr 0.
- Redirect to 0x203 in the same cycle as instr_ready in VALID → instruction dropped, next fetch addr 0x200.
- RESET_PC=0xFFFF_FFFC, fetch two words → addresses 0xFFFF_FFFC then 0x0000_0000.
- rst asserted while in DRAIN → next cycle all outputs at reset values; a late ack is ignored; first fetch from RESET_PC.
